// File: rtl/wdma_sched_pkg.sv
// Shared definitions for the write-DMA descriptor scheduler.
// Holds the one-hot scheduler state encoding, the DMA FSM status codes
// and the 40-bit buffer address type used by the scheduler and its queue.
package wdma_sched_pkg;

  localparam int ADDR_W = 40;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_OFFERED = 4'b0010,
    S_RUN     = 4'b0100,
    S_HALT    = 4'b1000
  } state_t;

  localparam logic [3:0] ST_NEXT         = 4'b0001;
  localparam logic [3:0] ST_NOVALID      = 4'b0010;
  localparam logic [3:0] ST_NOVALID_DONE = 4'b0011;
  localparam logic [3:0] ST_STOP         = 4'b0100;
  localparam logic [3:0] ST_TIMEOUT      = 4'b1000;

  // Codes that stop the FSM and make it drop its next-address latch.
  function automatic logic is_stop_code(input logic [3:0] st);
    return (st == ST_STOP) || (st == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/wdma_desc_fifo.sv
// Synchronous DEPTH x 40-bit descriptor queue.
// Ports: clk/rst (sync, active-high flush), push/din write side,
// pop/dout read side (dout shows the head combinationally),
// full/empty/level status derived from the registered occupancy count.
// A push while full is ignored; a pop while empty is ignored.
module wdma_desc_fifo
  import wdma_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  addr_t            din,
  input  logic             pop,
  output addr_t            dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  addr_t            mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign dout    = mem[rd_ptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wdma_desc_sched.sv
// Buffer-descriptor scheduler for the PCIe write-DMA FSM.
// Ports:
//   clk, rst, init_rst_i          clock, sync reset, host soft flush
//   desc_wr_i/desc_addr_i/desc_up_addr_i   host descriptor push
//   desc_full_o, desc_level_o, overflow_o  queue status
//   next_wdma_*                   one-cycle offer of the next buffer
//   wdma_running_i/irq_i/status_i FSM progress inputs
//   done_valid_o/addr_o/status_o, done_ack_i, done_lost_o  retirement record
//   halted_o                      scheduler stopped until reset
module wdma_desc_sched
  import wdma_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_rst_i,
  input  logic             desc_wr_i,
  input  logic [31:0]      desc_addr_i,
  input  logic [7:0]       desc_up_addr_i,
  output logic             desc_full_o,
  output logic [LVL_W-1:0] desc_level_o,
  output logic             overflow_o,
  output logic [31:0]      next_wdma_addr_o,
  output logic [7:0]       next_wdma_up_addr_o,
  output logic             next_wdma_valid_o,
  input  logic             wdma_running_i,
  input  logic             wdma_irq_i,
  input  logic [3:0]       wdma_status_i,
  output logic             done_valid_o,
  output logic [39:0]      done_addr_o,
  output logic [3:0]       done_status_o,
  input  logic             done_ack_i,
  output logic             done_lost_o,
  output logic             halted_o
);

  state_t state;
  logic   clr;
  logic   irq_d;
  logic   run_d;
  logic   samp_vld;
  logic   irq_rise;
  logic   run_rise;
  logic   offer_pend;
  logic   inflight_vld;
  logic   do_offer;
  logic   retire_en;
  logic   fifo_full;
  logic   fifo_empty;
  addr_t  fifo_head;
  addr_t  offer_addr;
  addr_t  inflight_addr;

  assign clr      = rst | init_rst_i;
  assign irq_rise = wdma_irq_i & ~irq_d;
  assign run_rise = wdma_running_i & ~run_d;
  assign halted_o = (state == S_HALT);
  assign desc_full_o = fifo_full;

  // No new offer in a status-sample cycle: that cycle may halt the
  // scheduler or free the offer slot, and popping then would lose a
  // descriptor or collide with the slot update.
  assign do_offer = ~offer_pend & ~fifo_empty & (state != S_HALT) & ~samp_vld;

  wdma_desc_fifo #(
    .DEPTH(DEPTH),
    .LVL_W(LVL_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (clr),
    .push (desc_wr_i),
    .din  ({desc_up_addr_i, desc_addr_i}),
    .pop  (do_offer),
    .dout (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty),
    .level(desc_level_o)
  );

  // Retirement only happens in RUN with a buffer actually in flight.
  always_comb begin
    retire_en = 1'b0;
    if ((state == S_RUN) && samp_vld && inflight_vld) begin
      case (wdma_status_i)
        ST_NEXT, ST_NOVALID_DONE, ST_STOP, ST_TIMEOUT: retire_en = 1'b1;
        default:                                       retire_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state               <= S_IDLE;
      irq_d               <= 1'b0;
      run_d               <= 1'b0;
      samp_vld            <= 1'b0;
      offer_pend          <= 1'b0;
      inflight_vld        <= 1'b0;
      overflow_o          <= 1'b0;
      next_wdma_valid_o   <= 1'b0;
      next_wdma_addr_o    <= '0;
      next_wdma_up_addr_o <= '0;
      done_valid_o        <= 1'b0;
      done_addr_o         <= '0;
      done_status_o       <= '0;
      done_lost_o         <= 1'b0;
    end else begin
      // Status lags irq by one cycle, so sample it the cycle after the rise.
      irq_d             <= wdma_irq_i;
      run_d             <= wdma_running_i;
      samp_vld          <= irq_rise;
      next_wdma_valid_o <= 1'b0;

      if (desc_wr_i && fifo_full) overflow_o <= 1'b1;

      if (do_offer) begin
        offer_pend          <= 1'b1;
        offer_addr          <= fifo_head;
        next_wdma_addr_o    <= fifo_head[31:0];
        next_wdma_up_addr_o <= fifo_head[39:32];
        next_wdma_valid_o   <= 1'b1;
      end

      // A same-cycle ack makes room for the new record, so no loss.
      if (retire_en) begin
        done_valid_o  <= 1'b1;
        done_addr_o   <= inflight_addr;
        done_status_o <= wdma_status_i;
        if (done_valid_o && !done_ack_i) done_lost_o <= 1'b1;
      end else if (done_ack_i) begin
        done_valid_o <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (samp_vld) begin
            state      <= S_HALT;
            offer_pend <= 1'b0;
          end else if (offer_pend) begin
            if (run_rise) begin
              inflight_addr <= offer_addr;
              inflight_vld  <= 1'b1;
              offer_pend    <= 1'b0;
              state         <= S_RUN;
            end else begin
              state <= S_OFFERED;
            end
          end
        end
        S_OFFERED: begin
          if (samp_vld && ((wdma_status_i == ST_NOVALID) || is_stop_code(wdma_status_i))) begin
            state      <= S_HALT;
            offer_pend <= 1'b0;
          end else if (run_rise) begin
            inflight_addr <= offer_addr;
            inflight_vld  <= 1'b1;
            offer_pend    <= 1'b0;
            state         <= S_RUN;
          end
        end
        S_RUN: begin
          if (samp_vld) begin
            case (wdma_status_i)
              ST_NEXT: begin
                inflight_addr <= offer_addr;
                inflight_vld  <= offer_pend;
                offer_pend    <= 1'b0;
              end
              ST_NOVALID_DONE, ST_STOP, ST_TIMEOUT: begin
                inflight_vld <= 1'b0;
                offer_pend   <= 1'b0;
                state        <= S_HALT;
              end
              default: ;
            endcase
          end
        end
        S_HALT:  ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wdma_desc_sched.sv
// Self-checking bench for wdma_desc_sched: directed scenarios plus a
// randomized sequence, all checked against a transaction-level model
// (descriptor queue, offer slot, in-flight slot, retirement record).
module tb_wdma_desc_sched;

  localparam int DEPTH = 4;
  localparam int LVL_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             init_rst_i = 1'b0;
  logic             desc_wr_i = 1'b0;
  logic [31:0]      desc_addr_i = '0;
  logic [7:0]       desc_up_addr_i = '0;
  logic             desc_full_o;
  logic [LVL_W-1:0] desc_level_o;
  logic             overflow_o;
  logic [31:0]      next_wdma_addr_o;
  logic [7:0]       next_wdma_up_addr_o;
  logic             next_wdma_valid_o;
  logic             wdma_running_i = 1'b0;
  logic             wdma_irq_i = 1'b0;
  logic [3:0]       wdma_status_i = '0;
  logic             done_valid_o;
  logic [39:0]      done_addr_o;
  logic [3:0]       done_status_o;
  logic             done_ack_i = 1'b0;
  logic             done_lost_o;
  logic             halted_o;

  always #5 clk = ~clk;

  wdma_desc_sched #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk(clk), .rst(rst), .init_rst_i(init_rst_i),
    .desc_wr_i(desc_wr_i), .desc_addr_i(desc_addr_i), .desc_up_addr_i(desc_up_addr_i),
    .desc_full_o(desc_full_o), .desc_level_o(desc_level_o), .overflow_o(overflow_o),
    .next_wdma_addr_o(next_wdma_addr_o), .next_wdma_up_addr_o(next_wdma_up_addr_o),
    .next_wdma_valid_o(next_wdma_valid_o), .wdma_running_i(wdma_running_i),
    .wdma_irq_i(wdma_irq_i), .wdma_status_i(wdma_status_i),
    .done_valid_o(done_valid_o), .done_addr_o(done_addr_o), .done_status_o(done_status_o),
    .done_ack_i(done_ack_i), .done_lost_o(done_lost_o), .halted_o(halted_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level reference model.
  logic [39:0] m_q[$];
  logic [39:0] exp_pulses[$];
  logic [39:0] m_offer, m_infl, m_done_addr;
  logic [3:0]  m_done_st;
  bit          m_pend, m_infl_v, m_run, m_halt, m_done_v, m_lost, m_ovf;

  // Offer-pulse monitor.
  logic [39:0] pulse_q[$];
  int          multi_pulse = 0;
  logic        prev_v = 1'b0;

  always @(negedge clk) begin
    if (next_wdma_valid_o) begin
      pulse_q.push_back({next_wdma_up_addr_o, next_wdma_addr_o});
      if (prev_v) multi_pulse++;
    end
    prev_v = next_wdma_valid_o;
  end

  function automatic logic [39:0] rnd_addr();
    logic [39:0] a;
    a[31:0]  = $urandom;
    a[39:32] = 8'($urandom_range(255, 0));
    return a;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    exp_pulses.delete();
    m_pend = 0; m_infl_v = 0; m_run = 0; m_halt = 0;
    m_done_v = 0; m_lost = 0; m_ovf = 0;
    m_offer = '0; m_infl = '0; m_done_addr = '0; m_done_st = '0;
  endfunction

  function automatic void model_fill();
    if (!m_pend && !m_halt && m_q.size() > 0) begin
      m_offer = m_q.pop_front();
      m_pend  = 1;
      exp_pulses.push_back(m_offer);
    end
  endfunction

  function automatic void model_push(input logic [39:0] a);
    if (m_q.size() < DEPTH) m_q.push_back(a);
    else m_ovf = 1;
    model_fill();
  endfunction

  function automatic void model_retire(input logic [39:0] a, input logic [3:0] st);
    if (m_done_v) m_lost = 1;
    m_done_v = 1; m_done_addr = a; m_done_st = st;
  endfunction

  function automatic void model_status(input logic [3:0] code);
    if (m_halt) begin
    end else if (!m_run) begin
      if (!m_pend) m_halt = 1;
      else if (code == 4'b0010 || code == 4'b0100 || code == 4'b1000) begin
        m_halt = 1; m_pend = 0;
      end
    end else begin
      case (code)
        4'b0001: begin
          if (m_infl_v) model_retire(m_infl, code);
          m_infl_v = m_pend; m_infl = m_offer; m_pend = 0;
          model_fill();
        end
        4'b0011, 4'b0100, 4'b1000: begin
          if (m_infl_v) model_retire(m_infl, code);
          m_infl_v = 0; m_pend = 0; m_halt = 1;
        end
        default: ;
      endcase
    end
  endfunction

  // Stimulus tasks: drive after the edge, sample after the edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    model_reset();
    pulse_q.delete();
  endtask

  task automatic push_desc(input logic [39:0] a);
    desc_wr_i = 1'b1;
    desc_addr_i = a[31:0];
    desc_up_addr_i = a[39:32];
    tick(1);
    desc_wr_i = 1'b0;
    model_push(a);
  endtask

  task automatic run_rise();
    wdma_running_i = 1'b0;
    tick(1);
    wdma_running_i = 1'b1;
    tick(1);
    if (!m_run && m_pend) begin
      m_run = 1; m_infl = m_offer; m_infl_v = 1; m_pend = 0;
      model_fill();
    end
  endtask

  task automatic irq_status(input logic [3:0] code);
    wdma_irq_i = 1'b1;
    tick(1);
    wdma_status_i = code;
    tick(1);
    wdma_irq_i = 1'b0;
    wdma_status_i = '0;
    model_status(code);
  endtask

  task automatic ack();
    done_ack_i = 1'b1;
    tick(1);
    done_ack_i = 1'b0;
    m_done_v = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    desc_wr_i = 1'b1;
    desc_addr_i = $urandom;
    wdma_irq_i = 1'b1;
    tick(3);
    rst = 1'b0;
    desc_wr_i = 1'b0;
    wdma_irq_i = 1'b0;
    tick(2);
    model_reset();
    pulse_q.delete();
    n_checks++;
    if ({desc_full_o, desc_level_o, overflow_o, next_wdma_valid_o} !== '0)
      $display("FAIL reset_queue: got full=%b lvl=%0d ovf=%b vld=%b want all 0",
               desc_full_o, desc_level_o, overflow_o, next_wdma_valid_o);
    else n_pass++;
    n_checks++;
    if ({next_wdma_up_addr_o, next_wdma_addr_o} !== 40'h0)
      $display("FAIL reset_next_addr: got %h want 0", {next_wdma_up_addr_o, next_wdma_addr_o});
    else n_pass++;
    n_checks++;
    if ({done_valid_o, done_addr_o, done_status_o, done_lost_o, halted_o} !== '0)
      $display("FAIL reset_done: got v=%b a=%h s=%b lost=%b halt=%b want all 0",
               done_valid_o, done_addr_o, done_status_o, done_lost_o, halted_o);
    else n_pass++;
  endtask

  task automatic test_offer();
    do_reset();
    push_desc(40'h00_1000_0000);
    push_desc(40'h00_1000_8000);
    tick(4);
    n_checks++;
    if (pulse_q.size() != 1 || pulse_q[0] !== 40'h0010000000)
      $display("FAIL offer_first: got %0d pulses want 1 with addr 0010000000", pulse_q.size());
    else n_pass++;
    n_checks++;
    if (desc_level_o !== LVL_W'(1))
      $display("FAIL offer_level_before_run: got %0d want 1", desc_level_o);
    else n_pass++;
    run_rise();
    tick(4);
    n_checks++;
    if (pulse_q.size() != 2 || pulse_q[1] !== 40'h0010008000)
      $display("FAIL offer_second: got %0d pulses want 2, second 0010008000", pulse_q.size());
    else n_pass++;
    n_checks++;
    if (desc_level_o !== LVL_W'(0))
      $display("FAIL offer_level_after_run: got %0d want 0", desc_level_o);
    else n_pass++;
    irq_status(4'b0001);
    tick(2);
    n_checks++;
    if (done_valid_o !== 1'b1 || done_addr_o !== 40'h0010000000 || done_status_o !== 4'b0001)
      $display("FAIL retire_next: got v=%b a=%h s=%b want v=1 a=0010000000 s=0001",
               done_valid_o, done_addr_o, done_status_o);
    else n_pass++;
    ack();
    tick(1);
    n_checks++;
    if (done_valid_o !== 1'b0)
      $display("FAIL ack_clear: got %b want 0", done_valid_o);
    else n_pass++;
    irq_status(4'b0001);
    tick(2);
    n_checks++;
    if (done_addr_o !== 40'h0010008000 || done_lost_o !== 1'b0 || halted_o !== 1'b0)
      $display("FAIL retire_inflight: got a=%h lost=%b halt=%b want a=0010008000 lost=0 halt=0",
               done_addr_o, done_lost_o, halted_o);
    else n_pass++;
  endtask

  task automatic test_novalid_done();
    logic [39:0] a;
    a = rnd_addr();
    do_reset();
    push_desc(a);
    tick(4);
    run_rise();
    tick(3);
    irq_status(4'b0011);
    tick(2);
    n_checks++;
    if (done_valid_o !== 1'b1 || done_addr_o !== a || done_status_o !== 4'b0011)
      $display("FAIL novalid_done_retire: got v=%b a=%h s=%b want v=1 a=%h s=0011",
               done_valid_o, done_addr_o, done_status_o, a);
    else n_pass++;
    n_checks++;
    if (halted_o !== 1'b1)
      $display("FAIL novalid_done_halt: got %b want 1", halted_o);
    else n_pass++;
    push_desc(rnd_addr());
    push_desc(rnd_addr());
    tick(5);
    n_checks++;
    if (pulse_q.size() != exp_pulses.size() || desc_level_o !== LVL_W'(m_q.size()))
      $display("FAIL halt_no_offer: got pulses=%0d lvl=%0d want pulses=%0d lvl=%0d",
               pulse_q.size(), desc_level_o, exp_pulses.size(), m_q.size());
    else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) push_desc(rnd_addr());
    tick(3);
    n_checks++;
    if (desc_full_o !== 1'b1 || overflow_o !== 1'b1)
      $display("FAIL overflow_flags: got full=%b ovf=%b want 1 1", desc_full_o, overflow_o);
    else n_pass++;
    n_checks++;
    if (desc_level_o !== LVL_W'(m_q.size()) || m_q.size() != DEPTH)
      $display("FAIL overflow_level: got %0d want %0d", desc_level_o, DEPTH);
    else n_pass++;
    n_checks++;
    if (pulse_q.size() != 1 || pulse_q[0] !== exp_pulses[0])
      $display("FAIL overflow_offer: got %0d pulses want 1", pulse_q.size());
    else n_pass++;
  endtask

  task automatic test_lost_and_init();
    logic [39:0] a, b, c, d;
    a = rnd_addr(); b = rnd_addr(); c = rnd_addr(); d = rnd_addr();
    do_reset();
    push_desc(a); push_desc(b); push_desc(c);
    tick(4);
    run_rise();
    tick(4);
    irq_status(4'b0001);
    tick(4);
    irq_status(4'b0001);
    tick(2);
    n_checks++;
    if (done_lost_o !== 1'b1 || done_addr_o !== b || m_done_addr !== b)
      $display("FAIL lost_record: got lost=%b a=%h want lost=1 a=%h", done_lost_o, done_addr_o, b);
    else n_pass++;
    init_rst_i = 1'b1;
    tick(1);
    init_rst_i = 1'b0;
    tick(1);
    model_reset();
    pulse_q.delete();
    n_checks++;
    if ({done_valid_o, done_addr_o, done_status_o, done_lost_o, halted_o, desc_level_o,
         desc_full_o, overflow_o, next_wdma_valid_o, next_wdma_addr_o, next_wdma_up_addr_o} !== '0)
      $display("FAIL init_rst_clear: got v=%b lost=%b lvl=%0d a=%h want all 0",
               done_valid_o, done_lost_o, desc_level_o, done_addr_o);
    else n_pass++;
    push_desc(d);
    tick(4);
    n_checks++;
    if (pulse_q.size() != 1 || pulse_q[0] !== d)
      $display("FAIL init_rst_idle_offer: got %0d pulses want 1 with %h", pulse_q.size(), d);
    else n_pass++;
  endtask

  task automatic test_timeout();
    logic [39:0] a, b, c, d;
    a = rnd_addr(); b = rnd_addr(); c = rnd_addr(); d = rnd_addr();
    do_reset();
    push_desc(a); push_desc(b);
    tick(4);
    run_rise();
    tick(4);
    push_desc(c);
    tick(3);
    irq_status(4'b1000);
    tick(2);
    n_checks++;
    if (done_valid_o !== 1'b1 || done_addr_o !== a || done_status_o !== 4'b1000)
      $display("FAIL timeout_retire: got v=%b a=%h s=%b want v=1 a=%h s=1000",
               done_valid_o, done_addr_o, done_status_o, a);
    else n_pass++;
    n_checks++;
    if (halted_o !== 1'b1 || desc_level_o !== LVL_W'(1) || m_q.size() != 1)
      $display("FAIL timeout_halt_queue: got halt=%b lvl=%0d want halt=1 lvl=1", halted_o, desc_level_o);
    else n_pass++;
    push_desc(d);
    tick(4);
    n_checks++;
    if (pulse_q.size() != 2 || desc_level_o !== LVL_W'(2))
      $display("FAIL timeout_no_reoffer: got pulses=%0d lvl=%0d want 2 2", pulse_q.size(), desc_level_o);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] codes [4];
    int         op;
    bit         ok;
    codes[0] = 4'b0001; codes[1] = 4'b0010; codes[2] = 4'b0101; codes[3] = 4'b0000;
    do_reset();
    for (int it = 0; it < 150; it++) begin
      op = $urandom_range(9, 0);
      if (op < 4) push_desc(rnd_addr());
      else if (op < 6) begin
        if (!m_run && m_pend) run_rise();
      end else if (op < 8) begin
        if (m_run) irq_status((op == 6) ? 4'b0001 : codes[$urandom_range(3, 0)]);
      end else ack();
      tick(4);
      n_checks++;
      if (desc_level_o !== LVL_W'(m_q.size()) || overflow_o !== m_ovf || halted_o !== m_halt)
        $display("FAIL rnd_queue it=%0d: got lvl=%0d ovf=%b halt=%b want lvl=%0d ovf=%b halt=%b",
                 it, desc_level_o, overflow_o, halted_o, m_q.size(), m_ovf, m_halt);
      else n_pass++;
      n_checks++;
      if (done_valid_o !== m_done_v || done_lost_o !== m_lost ||
          (m_done_v && (done_addr_o !== m_done_addr || done_status_o !== m_done_st)))
        $display("FAIL rnd_done it=%0d: got v=%b lost=%b a=%h s=%b want v=%b lost=%b a=%h s=%b",
                 it, done_valid_o, done_lost_o, done_addr_o, done_status_o,
                 m_done_v, m_lost, m_done_addr, m_done_st);
      else n_pass++;
    end
    irq_status(4'b0011);
    tick(4);
    ok = (pulse_q.size() == exp_pulses.size());
    for (int i = 0; i < pulse_q.size() && ok; i++) if (pulse_q[i] !== exp_pulses[i]) ok = 0;
    n_checks++;
    if (!ok || halted_o !== m_halt)
      $display("FAIL rnd_offers: got %0d pulses halt=%b want %0d pulses halt=%b",
               pulse_q.size(), halted_o, exp_pulses.size(), m_halt);
    else n_pass++;
  endtask

  task automatic test_pulse_width();
    n_checks++;
    if (multi_pulse != 0)
      $display("FAIL offer_pulse_width: got %0d multi-cycle pulses want 0", multi_pulse);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_offer();
    test_novalid_done();
    test_overflow();
    test_lost_and_init();
    test_timeout();
    test_random();
    test_pulse_width();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
